// File: rtl/t05_pkg.sv
// Shared histogram-stage definitions: SRAM command codes, EOF marker, reader states.
package t05_pkg;

  localparam logic [1:0] WR_R_IDLE  = 2'b00;
  localparam logic [1:0] WR_R_READ  = 2'b01;
  localparam logic [1:0] WR_R_WRITE = 2'b10;

  localparam logic [7:0] EOF_CHAR = 8'h1A;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    EMIT,
    NEXT,
    DONE
  } rd_state_t;

endpackage

// File: rtl/t05_hist_reader.sv
// Scans every histogram bin through the SRAM port and streams the nonzero (char, count) pairs.
// A zero bin costs 3 cycles with 1-cycle ack; a pending pair stalls the scan until out_ready.
module t05_hist_reader
  import t05_pkg::*;
#(
  parameter int NUM_BINS = 256,
  parameter int CNT_W    = 32,
  parameter int ADDR_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_total_in,
  output logic [ADDR_W-1:0] o_hist_addr,
  output logic [1:0]        o_wr_r_en,
  input  logic [CNT_W-1:0]  i_sram_in,
  input  logic              i_sram_ack,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [7:0]        o_out_char,
  output logic [CNT_W-1:0]  o_out_count,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_num_symbols,
  output logic              o_sum_mismatch
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);

  rd_state_t         r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_wr_r_en;
  logic              r_out_valid;
  logic [7:0]        r_out_char;
  logic [CNT_W-1:0]  r_out_count;
  logic [CNT_W-1:0]  r_sum;
  logic [CNT_W-1:0]  r_total;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W:0]   r_num_symbols;
  logic              r_sum_mismatch;
  logic              r_armed;

  logic [CNT_W-1:0]  w_sum_next;

  assign w_sum_next = r_sum + i_sram_in;

  // r_armed keeps a start that coincides with reset release from launching a scan.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state        <= IDLE;
      r_addr         <= '0;
      r_wr_r_en      <= WR_R_IDLE;
      r_out_valid    <= 1'b0;
      r_out_char     <= '0;
      r_out_count    <= '0;
      r_sum          <= '0;
      r_total        <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_num_symbols  <= '0;
      r_sum_mismatch <= 1'b0;
      r_armed        <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start && r_armed) begin
            r_total        <= i_total_in;
            r_sum          <= '0;
            r_num_symbols  <= '0;
            r_sum_mismatch <= 1'b0;
            r_addr         <= '0;
            r_busy         <= 1'b1;
            r_wr_r_en      <= WR_R_READ;
            r_state        <= REQ;
          end
        end
        REQ: r_state <= WAIT;
        WAIT: begin
          if (i_sram_ack) begin
            r_sum     <= w_sum_next;
            r_wr_r_en <= WR_R_IDLE;
            if (i_sram_in != '0) begin
              r_out_char    <= 8'(r_addr);
              r_out_count   <= i_sram_in;
              r_out_valid   <= 1'b1;
              r_num_symbols <= r_num_symbols + (ADDR_W + 1)'(1);
              r_state       <= EMIT;
            end else begin
              r_state <= NEXT;
            end
          end
        end
        EMIT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= NEXT;
          end
        end
        NEXT: begin
          if (r_addr == LAST_ADDR) begin
            r_done         <= 1'b1;
            r_sum_mismatch <= (r_sum != r_total);
            r_state        <= DONE;
          end else begin
            r_addr    <= r_addr + ADDR_W'(1);
            r_wr_r_en <= WR_R_READ;
            r_state   <= REQ;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_hist_addr    = r_addr;
  assign o_wr_r_en      = r_wr_r_en;
  assign o_out_valid    = r_out_valid;
  assign o_out_char     = r_out_char;
  assign o_out_count    = r_out_count;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_num_symbols  = r_num_symbols;
  assign o_sum_mismatch = r_sum_mismatch;

endmodule

// File: tb/tb_t05_hist_reader.sv
// Randomized scoreboard bench for t05_hist_reader with an SRAM model and a pair-stream monitor.
module tb_t05_hist_reader;

  localparam int NB = 256;
  localparam int LIM = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] total_in = '0;
  logic [7:0]  hist_addr;
  logic [1:0]  wr_r_en;
  logic [31:0] sram_in = '0;
  logic        sram_ack = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_char;
  logic [31:0] out_count;
  logic        busy;
  logic        done;
  logic [8:0]  num_symbols;
  logic        sum_mismatch;

  t05_hist_reader dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_start       (start),
    .i_total_in    (total_in),
    .o_hist_addr   (hist_addr),
    .o_wr_r_en     (wr_r_en),
    .i_sram_in     (sram_in),
    .i_sram_ack    (sram_ack),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_char    (out_char),
    .o_out_count   (out_count),
    .o_busy        (busy),
    .o_done        (done),
    .o_num_symbols (num_symbols),
    .o_sum_mismatch(sum_mismatch)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  ch;
    logic [31:0] cnt;
  } pair_t;

  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] mem [NB];
  pair_t       exp_q[$];
  int          exp_syms = 0;
  bit          exp_mis = 1'b0;
  int          ack_dly = 1;
  int          rdy_mode = 0;
  int          stall_left = 0;
  bit          spur = 1'b0;
  int          rd_exp = 0;
  int          rq_cnt = 0;
  logic [7:0]  rq_addr = '0;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // SRAM model: acks ack_dly cycles after the request cycle, optionally fires stray acks in EMIT.
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      sram_ack = 1'b0;
      rq_cnt   = 0;
    end else begin
      if (out_valid) chk("no_read_in_emit", wr_r_en, 0);
      if (wr_r_en == 2'b01) begin
        if (rq_cnt == 0) rq_addr = hist_addr;
        else chk("addr_hold", hist_addr, rq_addr);
        rq_cnt++;
        if (rq_cnt == ack_dly + 1) begin
          sram_ack = 1'b1;
          sram_in  = mem[hist_addr];
          chk("read_order", hist_addr, rd_exp);
          rd_exp++;
        end else begin
          sram_ack = 1'b0;
        end
      end else begin
        rq_cnt = 0;
        if (spur && out_valid && !sram_ack) begin
          sram_ack = 1'b1;
          sram_in  = 32'd9;
        end else begin
          sram_ack = 1'b0;
          sram_in  = $urandom;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && out_char == 8'd65 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  end

  // Monitor: every presented pair must match the scoreboard head until it is accepted.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pair", out_char, -1);
      end else begin
        chk("out_char", out_char, exp_q[0].ch);
        chk("out_count", out_count, exp_q[0].cnt);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (rst_n && done) begin
      chk("pairs_left_at_done", exp_q.size(), 0);
      chk("num_symbols", num_symbols, exp_syms);
      chk("sum_mismatch", sum_mismatch, exp_mis);
    end
  end

  task automatic load_expect(input logic [31:0] tot);
    logic [31:0] s;
    s = '0;
    exp_q.delete();
    exp_syms = 0;
    for (int i = 0; i < NB; i++) begin
      s = s + mem[i];
      if (mem[i] != 0) begin
        exp_q.push_back(pair_t'{ch: 8'(i), cnt: mem[i]});
        exp_syms++;
      end
    end
    exp_mis = (s != tot);
    rd_exp = 0;
  endtask

  task automatic run_scan(input string tag, input logic [31:0] tot, input int exp_cyc, input bit poke);
    int cyc;
    load_expect(tot);
    @(posedge clk);
    #1;
    total_in = tot;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    total_in = $urandom;
    chk({tag, "_busy_after_start"}, busy, 1);
    cyc = 0;
    while (!done && cyc < LIM) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (poke && cyc == 50);
    end
    start = 1'b0;
    chk({tag, "_done_timeout"}, int'(cyc < LIM), 1);
    if (exp_cyc >= 0) chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_reads_issued"}, rd_exp, NB);
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_busy_cleared"}, busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hist_addr"}, hist_addr, 0);
    chk({tag, "_wr_r_en"}, wr_r_en, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_char"}, out_char, 0);
    chk({tag, "_out_count"}, out_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_num_symbols"}, num_symbols, 0);
    chk({tag, "_sum_mismatch"}, sum_mismatch, 0);
  endtask

  task automatic set_sample_mem();
    for (int i = 0; i < NB; i++) mem[i] = '0;
    mem[65] = 32'd2;
    mem[66] = 32'd1;
    mem[67] = 32'd1;
    mem[26] = 32'd1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NB; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");

    // Start coincident with reset release must be ignored.
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("start_at_release_busy", busy, 0);
    chk("start_at_release_wr", wr_r_en, 0);

    set_sample_mem();
    run_scan("t1", 32'd5, 252 * 3 + 4 * 4, 1'b0);

    for (int i = 0; i < NB; i++) mem[i] = '0;
    run_scan("t2", 32'd0, 768, 1'b0);

    set_sample_mem();
    run_scan("t3", 32'd6, 252 * 3 + 4 * 4, 1'b0);

    rdy_mode = 2;
    stall_left = 5;
    spur = 1'b1;
    run_scan("t4", 32'd5, 252 * 3 + 4 * 4 + 5, 1'b0);
    spur = 1'b0;
    rdy_mode = 0;

    ack_dly = 4;
    run_scan("t5", 32'd5, 252 * 6 + 4 * 7, 1'b1);

    rdy_mode = 1;
    for (int it = 0; it < 4; it++) begin
      logic [31:0] s;
      s = '0;
      ack_dly = int'($urandom_range(1, 3));
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 3) == 0)
          mem[i] = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(1, 50));
        else
          mem[i] = '0;
        s = s + mem[i];
      end
      run_scan("rand", (it % 2 == 0) ? s : s + 32'($urandom_range(1, 9)), -1, 1'b0);
    end

    rdy_mode = 0;
    ack_dly = 1;
    for (int i = 0; i < NB; i++) mem[i] = 32'd1;
    run_scan("t6", 32'd256, 256 * 4, 1'b0);

    // Rerun and abort mid-scan with an asynchronous reset.
    load_expect(32'd256);
    @(posedge clk);
    #1;
    total_in = 32'd256;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midscan_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_scan("t6_rerun", 32'd256, 256 * 4, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/t05_hist_reader.md
Name: t05_hist_reader

Overview:
Read-back side of the histogram stage. After t05_histogram has written per-character counts into SRAM (bins 0..255), this block walks every bin through the same SRAM port. It emits each nonzero (character, count) pair on a valid/ready stream to the tree-building logic, reports the number of distinct symbols, and cross-checks the summed counts against the histogram's running total.

Parameters:
NUM_BINS, 256, number of histogram bins scanned (addresses 0..NUM_BINS-1)
CNT_W, 32, width of one bin count and of the sum accumulator
ADDR_W, 8, bin address width; must satisfy 2**ADDR_W >= NUM_BINS

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  one-cycle pulse; begins a scan when in IDLE
total_in  input  CNT_W  expected character count, taken from t05_histogram total
hist_addr  output  ADDR_W  SRAM bin address
wr_r_en  output  2  SRAM command: 2'b01 = read, 2'b00 = idle; this block never writes
sram_in  input  CNT_W  SRAM read data, valid in the cycle sram_ack=1
sram_ack  input  1  SRAM read complete
out_valid  output  1  out_char/out_count valid
out_ready  input  1  downstream accepts the pair when out_valid&&out_ready
out_char  output  8  bin index (character code)
out_count  output  CNT_W  bin count, always nonzero when out_valid=1
busy  output  1  high from start acceptance until DONE
done  output  1  one-cycle pulse when the scan finishes
num_symbols  output  ADDR_W+1  number of nonzero bins, held after done
sum_mismatch  output  1  sum of counts != total_in, held after done

Behaviour:
- Reset (rst=0, async): state=IDLE. hist_addr=0, wr_r_en=00, out_valid=0, out_char=0, out_count=0, busy=0, done=0, num_symbols=0, sum_mismatch=0. Internal sum=0 and total latch=0.
- IDLE: start=1 moves to REQ. In the same edge: latch total_in, clear sum, num_symbols and sum_mismatch, set addr=0, busy=1.
- REQ: drive wr_r_en=01 and hist_addr=addr. Move to WAIT on the next edge.
- WAIT: hold wr_r_en=01 and hist_addr until sram_ack=1. There is no timeout.
- On the sram_ack edge: capture sram_in, add it to sum (modulo 2**CNT_W), and drop wr_r_en to 00.
  - Count nonzero: set out_char=addr, out_count=sram_in, out_valid=1, increment num_symbols, go to EMIT.
  - Count zero: go to NEXT.
- EMIT: out_valid, out_char and out_count stay stable until out_valid&&out_ready. On that edge clear out_valid and go to NEXT.
- NEXT: if addr==NUM_BINS-1, go to DONE. Otherwise addr+1 and go to REQ. The address never wraps.
- DONE: pulse done=1 for one cycle. Set sum_mismatch=(sum!=latched total). Clear busy and return to IDLE.
- Timing: a zero bin takes 3 cycles with a 1-cycle ack (REQ, WAIT, NEXT). A nonzero bin adds at least 1 cycle in EMIT.
- Pairs are emitted in strictly ascending out_char order.
- start while busy=1 is ignored. start in the same cycle as a reset release is ignored.
- An all-zero histogram produces no out_valid, then done with num_symbols=0.
- A histogram with all 256 bins nonzero gives num_symbols=256, hence the 9-bit width.
- sram_ack outside WAIT is ignored.
- Reset mid-scan aborts immediately to reset values. A pending output pair is dropped.
- out_ready held high gives one EMIT cycle per nonzero bin.

Decomposition:
- Shared package t05_pkg holds:
  - the SRAM command encodings (WR_R_IDLE=2'b00, WR_R_READ=2'b01, WR_R_WRITE=2'b10)
  - EOF_CHAR=8'h1A
  - the reader state enum (IDLE, REQ, WAIT, EMIT, NEXT, DONE)
- No sub-module is needed. The output register (valid/char/count hold) can be a small sub-module, t05_pair_reg, if it is reused by the tree builder.

Test Plan:
1. Memory model with bins 65=2, 66=1, 67=1, 26=1, rest 0; 1-cycle ack; out_ready=1; total_in=5 -> pairs (26,1),(65,2),(66,1),(67,1) in order; done pulse; num_symbols=4; sum_mismatch=0; hist_addr reaches 255 exactly once.
2. All bins zero, total_in=0 -> out_valid never asserted; done after 768 cycles with 1-cycle ack; num_symbols=0; sum_mismatch=0.
3. Same memory as test 1 with total_in=6 -> identical pair stream; sum_mismatch=1 at done.
4. out_ready low for 5 cycles while (65,2) is presented -> out_char=65 and out_count=2 stay stable; no further hist_addr read is issued until the handshake completes.
5. sram_ack delayed 4 cycles per read -> wr_r_en=01 and hist_addr held steady through WAIT; results identical to test 1.
6. All 256 bins = 1, total_in=256 -> 256 pairs, num_symbols=256, sum_mismatch=0. Then assert rst=0 mid-scan on a rerun -> all outputs return to reset values asynchronously, and a new start restarts from address 0.
